// File: rtl/scie_pipelined.sv
// Five-tap complex FIR custom-instruction unit: coefficient load, sample push and
// registered dot-product read, each taking effect on one qualified clock edge.
module scie_pipelined (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_valid,
    input  logic [31:0]        io_insn,
    input  logic signed [15:0] io_rs1_real,
    input  logic signed [15:0] io_rs1_imag,
    input  logic [31:0]        io_rs2,
    output logic signed [15:0] io_rd_real,
    output logic signed [15:0] io_rd_imag
);

    localparam int          NTAP       = 5;
    localparam logic [6:0]  OP_SETCOEF = 7'h0B;
    localparam logic [6:0]  OP_PUSH    = 7'h2B;
    localparam logic [6:0]  OP_READ    = 7'h5B;

    logic signed [15:0] r_c_re [NTAP];
    logic signed [15:0] r_c_im [NTAP];
    logic signed [15:0] r_x_re [NTAP];
    logic signed [15:0] r_x_im [NTAP];

    logic [6:0]  w_opcode;
    logic        w_do_set;
    logic        w_do_push;
    logic        w_do_read;
    logic        w_unused_insn;

    logic signed [31:0] w_p_ac [NTAP];
    logic signed [31:0] w_p_bd [NTAP];
    logic signed [31:0] w_p_ad [NTAP];
    logic signed [31:0] w_p_bc [NTAP];
    logic signed [35:0] w_acc_re;
    logic signed [35:0] w_acc_im;

    assign w_opcode      = io_insn[6:0];
    assign w_unused_insn = ^io_insn[31:7];

    assign w_do_set  = io_valid && (w_opcode == OP_SETCOEF);
    assign w_do_push = io_valid && (w_opcode == OP_PUSH);
    assign w_do_read = io_valid && (w_opcode == OP_READ);

    // Partial products at full 32-bit precision; operands are sign-extended first.
    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            w_p_ac[k] = 32'(r_c_re[k]) * 32'(r_x_re[k]);
            w_p_bd[k] = 32'(r_c_im[k]) * 32'(r_x_im[k]);
            w_p_ad[k] = 32'(r_c_re[k]) * 32'(r_x_im[k]);
            w_p_bc[k] = 32'(r_c_im[k]) * 32'(r_x_re[k]);
        end
    end

    // 36-bit accumulation leaves headroom for five full-scale terms; only the
    // low 16 bits are kept, so the result wraps rather than saturates.
    always_comb begin
        w_acc_re = '0;
        w_acc_im = '0;
        for (int k = 0; k < NTAP; k++) begin
            w_acc_re = w_acc_re + 36'(w_p_ac[k]) - 36'(w_p_bd[k]);
            w_acc_im = w_acc_im + 36'(w_p_ad[k]) + 36'(w_p_bc[k]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAP; k++) begin
                r_c_re[k] <= '0;
                r_c_im[k] <= '0;
            end
        end else if (w_do_set) begin
            for (int k = 0; k < NTAP; k++) begin
                if (io_rs2 == 32'(k)) begin
                    r_c_re[k] <= io_rs1_real;
                    r_c_im[k] <= io_rs1_imag;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAP; k++) begin
                r_x_re[k] <= '0;
                r_x_im[k] <= '0;
            end
        end else if (w_do_push) begin
            for (int k = NTAP - 1; k > 0; k--) begin
                r_x_re[k] <= r_x_re[k-1];
                r_x_im[k] <= r_x_im[k-1];
            end
            r_x_re[0] <= io_rs1_real;
            r_x_im[0] <= io_rs1_imag;
        end
    end

    // Result register samples the pre-edge delay line, giving one-cycle latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_rd_real <= '0;
            io_rd_imag <= '0;
        end else if (w_do_read) begin
            io_rd_real <= w_acc_re[15:0];
            io_rd_imag <= w_acc_im[15:0];
        end
    end

endmodule

// File: tb/tb_scie_pipelined.sv
// Directed bench for scie_pipelined: hand-computed vectors plus a small FIR model
// for the delay-line drop-out and filtering checks.
module tb_scie_pipelined;

    localparam logic [31:0] OP_SET  = 32'h0000_000B;
    localparam logic [31:0] OP_PUSH = 32'h0000_002B;
    localparam logic [31:0] OP_READ = 32'h0000_005B;

    logic               clock;
    logic               reset;
    logic               io_valid;
    logic [31:0]        io_insn;
    logic signed [15:0] io_rs1_real;
    logic signed [15:0] io_rs1_imag;
    logic [31:0]        io_rs2;
    logic signed [15:0] io_rd_real;
    logic signed [15:0] io_rd_imag;

    int n_vec;
    int n_err;

    int m_cr [5];
    int m_ci [5];
    int m_xr [5];
    int m_xi [5];

    scie_pipelined dut (
        .clock       (clock),
        .reset       (reset),
        .io_valid    (io_valid),
        .io_insn     (io_insn),
        .io_rs1_real (io_rs1_real),
        .io_rs1_imag (io_rs1_imag),
        .io_rs2      (io_rs2),
        .io_rd_real  (io_rd_real),
        .io_rd_imag  (io_rd_imag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 5; k++) begin
            m_cr[k] = 0; m_ci[k] = 0; m_xr[k] = 0; m_xi[k] = 0;
        end
    endtask

    task automatic do_insn(input logic v, input logic [31:0] insn,
                           input logic signed [15:0] re, input logic signed [15:0] im,
                           input logic [31:0] rs2);
        @(negedge clock);
        io_valid    = v;
        io_insn     = insn;
        io_rs1_real = re;
        io_rs1_imag = im;
        io_rs2      = rs2;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        do_insn(1'b0, 32'h0, 16'sd0, 16'sd0, 32'd0);
    endtask

    task automatic setcoef(input logic [31:0] idx, input int re, input int im);
        do_insn(1'b1, OP_SET, 16'(re), 16'(im), idx);
        if (idx < 5) begin
            m_cr[idx] = re;
            m_ci[idx] = im;
        end
    endtask

    task automatic push(input int re, input int im);
        do_insn(1'b1, OP_PUSH, 16'(re), 16'(im), 32'd0);
        for (int k = 4; k > 0; k--) begin
            m_xr[k] = m_xr[k-1];
            m_xi[k] = m_xi[k-1];
        end
        m_xr[0] = re;
        m_xi[0] = im;
    endtask

    task automatic read_chk(input string tag, input int er, input int ei);
        do_insn(1'b1, OP_READ, 16'sd0, 16'sd0, 32'd0);
        chk({tag, ".re"}, io_rd_real, 16'(er));
        chk({tag, ".im"}, io_rd_imag, 16'(ei));
    endtask

    task automatic read_model(input string tag);
        longint sr;
        longint si;
        sr = 0;
        si = 0;
        for (int k = 0; k < 5; k++) begin
            sr += longint'(m_cr[k]) * m_xr[k] - longint'(m_ci[k]) * m_xi[k];
            si += longint'(m_cr[k]) * m_xi[k] + longint'(m_ci[k]) * m_xr[k];
        end
        read_chk(tag, int'(sr[15:0]), int'(si[15:0]));
    endtask

    task automatic load_base();
        setcoef(32'd0,   3, -21);
        setcoef(32'd1, -10, -13);
        setcoef(32'd2, -12,  20);
        setcoef(32'd3, -28,  33);
        setcoef(32'd4,  -4,   2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_clear();
        reset       = 1'b0;
        io_valid    = 1'b0;
        io_insn     = '0;
        io_rs1_real = '0;
        io_rs1_imag = '0;
        io_rs2      = '0;
        #12;
        chk("rst.re", io_rd_real, 16'sd0);
        chk("rst.im", io_rd_imag, 16'sd0);
        @(negedge clock);
        reset = 1'b1;

        // Reference sequence
        load_base();
        push(-27, -25);
        idle();
        read_chk("r1", -606, 492);
        idle();
        chk("hold.re", io_rd_real, -16'sd606);
        push(-16, -28);
        chk("hold_push.im", io_rd_imag, 16'sd492);
        read_chk("r2", -691, 853);
        push(-36, -32);
        read_chk("r3", -160, 908);
        push(-34, -14);
        read_chk("r4", 1881, 1285);

        // Ignored instructions must leave state untouched
        setcoef(32'd5, 999, 999);
        setcoef(32'h8000_0001, 777, -777);
        do_insn(1'b0, OP_SET, 16'sd500, 16'sd500, 32'd0);
        do_insn(1'b0, OP_PUSH, 16'sd123, 16'sd456, 32'd0);
        do_insn(1'b1, 32'h0000_007B, 16'sd11, 16'sd22, 32'd2);
        do_insn(1'b0, OP_READ, 16'sd0, 16'sd0, 32'd0);
        chk("noread.re", io_rd_real, 16'sd1881);
        read_chk("ignored", 1881, 1285);

        // Upper instruction bits are don't-care; oldest samples drop out
        do_insn(1'b1, 32'hFFFF_FF80 | OP_PUSH, 16'sd100, -16'sd7, 32'd3);
        m_xr[4] = m_xr[3]; m_xi[4] = m_xi[3];
        m_xr[3] = m_xr[2]; m_xi[3] = m_xi[2];
        m_xr[2] = m_xr[1]; m_xi[2] = m_xi[1];
        m_xr[1] = m_xr[0]; m_xi[1] = m_xi[0];
        m_xr[0] = 100;     m_xi[0] = -7;
        read_model("p5");
        push(5, 9);
        read_model("p6");
        push(-300, 2);
        read_model("p7");
        push(1, 1);
        push(7, -8);
        read_model("p9");
        push(20, 20);
        read_model("p10");
        setcoef(32'd4, 1000, -500);
        read_model("newc4");

        // Full-scale wrap
        for (int k = 0; k < 5; k++) setcoef(32'(k), 32767, 0);
        for (int k = 0; k < 5; k++) push(32767, 0);
        read_chk("wrap", 5, 0);

        // Mid-sequence reset discards everything
        load_base();
        push(-27, -25);
        @(posedge clock);
        #3;
        reset = 1'b0;
        m_clear();
        #1;
        chk("mrst.re", io_rd_real, 16'sd0);
        chk("mrst.im", io_rd_imag, 16'sd0);
        @(negedge clock);
        reset = 1'b1;
        push(5, 5);
        read_chk("post_rst", 0, 0);
        setcoef(32'd0, 1, 0);
        read_chk("post_rst_c0", 5, 5);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scie_pipelined.md
SCIE_PIPELINED -- requirements
Module: scie_pipelined

Interface
REQ-001 SHALL: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset; clears all state immediately while low.
REQ-003 SHALL: io_valid  input  1  instruction-valid qualifier; when 0 the cycle is ignored.
REQ-004 SHALL: io_insn  input  32  instruction word; only opcode field io_insn[6:0] is decoded, other bits ignored.
REQ-005 SHALL: io_rs1_real  input  16  signed real part of operand rs1.
REQ-006 SHALL: io_rs1_imag  input  16  signed imaginary part of operand rs1.
REQ-007 SHALL: io_rs2  input  32  unsigned operand rs2; used as coefficient index.
REQ-008 SHALL: io_rd_real  output  16  signed real part of registered result.
REQ-009 SHALL: io_rd_imag  output  16  signed imaginary part of registered result.

Function
REQ-010 SHALL: implement a 5-tap complex FIR: coefficient registers c0..c4 and sample delay line x0 (newest)..x4 (oldest), each complex with 16-bit signed real/imag.
REQ-011 SHALL: act only on a rising edge with io_valid=1; opcodes other than those below, or io_valid=0, change no state.
REQ-012 SHALL: opcode 0x0B (SETCOEF): c[io_rs2] <= (io_rs1_real, io_rs1_imag) for io_rs2 in 0..4; io_rs2 >= 5 has no effect; delay line and outputs unchanged.
REQ-013 SHALL: opcode 0x2B (PUSH): x4<=x3, x3<=x2, x2<=x1, x1<=x0, x0<=(io_rs1_real, io_rs1_imag); coefficients and outputs unchanged.
REQ-014 SHALL: opcode 0x5B (READ): rd <= sum over k=0..4 of ck*xk, using the delay line contents before this edge; result visible on io_rd_* after that edge (1-cycle latency).
REQ-015 SHALL: complex product (a+jb)(c+jd) = (ac-bd) + j(ad+bc); products computed at 32-bit signed, sums accumulated at 32 bits or wider, and the final real/imag each truncated to low 16 bits (two's-complement wrap, no saturation).
REQ-016 SHALL: io_rd_real/io_rd_imag hold their last value between READ instructions.
REQ-017 SHALL: back-to-back instructions on consecutive cycles are each accepted (no stall, no ready signal); a READ the cycle after a PUSH sees the pushed sample.
REQ-018 SHALL: coefficients persist across any number of PUSH/READ operations until overwritten or reset.
REQ-019 SHALL: the multiply/accumulate path may be internally pipelined only if the REQ-014 one-cycle latency is preserved.

Reset
REQ-020 SHALL: while reset is low, c0..c4, x0..x4, io_rd_real and io_rd_imag are 0, asynchronously.
REQ-021 SHALL: reset asserted mid-sequence discards all loaded coefficients and samples; first instruction accepted is on the first rising edge after reset returns high.

Verification
REQ-022 SHALL: load c0..c4 = (3,-21),(-10,-13),(-12,20),(-28,33),(-4,2) via SETCOEF idx 0..4; PUSH (-27,-25); idle cycle; READ -> rd = (-606, 492).
REQ-023 SHALL: continuing, PUSH (-16,-28), READ -> (-691, 853); PUSH (-36,-32), READ -> (-160, 908); PUSH (-34,-14), READ -> (1881, 1285).
REQ-024 SHALL: SETCOEF with io_rs2=5 or io_valid=0 instructions -> subsequent READ results identical to the run without them.
REQ-025 SHALL: after 5+ pushes, oldest samples drop out: a PUSH of a sample followed by READ equals the 5-term sum of the latest five samples only (checked against software model).
REQ-026 SHALL: coefficients (32767,0) in all taps and five pushes of (32767,0) -> READ result equals low 16 bits of 5*32767^2 (wrap check, real=5, imag=0).
REQ-027 SHALL: assert reset low after REQ-022 setup, release, PUSH (5,5), READ -> (0,0); io_rd_* read 0 during reset.
